disp_seq_ctrl: RTL and testbench

- Sequencer between the calculator datapath's 27-bit result register and the 8-digit display bus (`data`/`pos`).
- On a start pulse it captures a binary value and converts it to 8 BCD digits, iteratively via double-dabble, one bit per cycle.
- It then scans the digits onto `data`/`pos`, one digit per cycle, and signals completion so the datapath can return its status to ready.
- Replaces ad-hoc per-cycle modulo/divide display logic with a deterministic, fixed-latency handshake.

---
 rtl/calc_pkg.sv | 29 ++
 rtl/bin2bcd_seq.sv | 47 ++++
 rtl/disp_seq_ctrl.sv | 166 ++++++++++++++++
 tb/tb_disp_seq_ctrl.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared constants for the calculator core and its display sequencer.
// Holds the sequencer state codes, display special codes and status encodings.
package calc_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t CONV = 2'd1;
    localparam state_t SCAN = 2'd2;
    localparam state_t DONE = 2'd3;

    localparam logic [3:0] BLANK_CODE = 4'hA;
    localparam logic [3:0] OVF_CODE   = 4'hF;

    localparam logic [1:0] STATUS_ERR   = 2'b00;
    localparam logic [1:0] STATUS_BUSY  = 2'b01;
    localparam logic [1:0] STATUS_READY = 2'b10;

    // 10^n as a 64-bit constant; used to derive the largest displayable value.
    function automatic logic [63:0] pow10(input int unsigned n);
        logic [63:0] r;
        r = 64'd1;
        for (int unsigned i = 0; i < n; i++) begin
            r = r * 64'd10;
        end
        return r;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble core: one binary bit is shifted into the BCD register per step.
// bcd_next exposes the result of the pending step so the caller can use it on the same edge.
module bin2bcd_seq #(
    parameter int unsigned VALUE_W = 27,
    parameter int unsigned NDIG    = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 load,
    input  logic                 step,
    input  logic [VALUE_W-1:0]   value,
    output logic [4*NDIG-1:0]    bcd,
    output logic [4*NDIG-1:0]    bcd_next
);

    logic [VALUE_W-1:0] sh_q;
    logic [VALUE_W-1:0] sh_next;
    logic [4*NDIG-1:0]  bcd_q;
    logic [4*NDIG-1:0]  adj;

    always_comb begin
        adj = bcd_q;
        for (int i = 0; i < int'(NDIG); i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
        // Bits carried out of the top digit are dropped; the caller flags that case as overflow.
        {bcd_next, sh_next} = {adj, sh_q} << 1;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sh_q  <= '0;
            bcd_q <= '0;
        end else if (load) begin
            sh_q  <= value;
            bcd_q <= '0;
        end else if (step) begin
            sh_q  <= sh_next;
            bcd_q <= bcd_next;
        end
    end

    assign bcd = bcd_q;

endmodule

// File: rtl/disp_seq_ctrl.sv
// Display sequencer: captures a binary result, converts it to BCD and scans the digits
// onto the data/pos bus with a fixed-latency start/done handshake.
module disp_seq_ctrl
    import calc_pkg::*;
#(
    parameter int unsigned VALUE_W  = 27,
    parameter int unsigned NDIG     = 8,
    parameter int unsigned LZ_BLANK = 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic [VALUE_W-1:0] value,
    output logic               busy,
    output logic               done,
    output logic               valid,
    output logic [3:0]         data,
    output logic [3:0]         pos,
    output logic               ovf
);

    localparam int unsigned CNT_W   = $clog2(VALUE_W + 1);
    localparam logic [63:0] MAX_VAL = pow10(NDIG) - 64'd1;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               valid_q, valid_d;
    logic [3:0]         data_q, data_d;
    logic [3:0]         pos_q, pos_d;
    logic               ovf_q, ovf_d;
    logic               load, step;
    logic               value_ovf;
    logic [4*NDIG-1:0]  bcd, bcd_next;

    bin2bcd_seq #(
        .VALUE_W (VALUE_W),
        .NDIG    (NDIG)
    ) u_bin2bcd (
        .clock    (clock),
        .reset    (reset),
        .load     (load),
        .step     (step),
        .value    (value),
        .bcd      (bcd),
        .bcd_next (bcd_next)
    );

    assign value_ovf = 64'(value) > MAX_VAL;

    // Display code for one digit, applying overflow fill and leading-zero blanking.
    function automatic logic [3:0] scan_digit(input logic [4*NDIG-1:0] b,
                                              input logic [3:0]        idx,
                                              input logic              is_ovf);
        int         msd;
        logic [3:0] d;
        msd = 0;
        for (int i = 0; i < int'(NDIG); i++) begin
            if (b[4*i +: 4] != 4'd0) begin
                msd = i;
            end
        end
        d = b[4*idx +: 4];
        if (is_ovf) begin
            return OVF_CODE;
        end else if (LZ_BLANK != 0 && idx != 4'd0 && int'(idx) > msd) begin
            return BLANK_CODE;
        end
        return d;
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        valid_d = 1'b0;
        data_d  = 4'd0;
        pos_d   = 4'd0;
        ovf_d   = ovf_q;
        load    = 1'b0;
        step    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    load    = 1'b1;
                    state_d = CONV;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    ovf_d   = value_ovf;
                end
            end
            CONV: begin
                if (abort) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else begin
                    step  = 1'b1;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(VALUE_W - 1)) begin
                        // Last iteration: present digit 0 from the just-finished result.
                        state_d = SCAN;
                        valid_d = 1'b1;
                        pos_d   = 4'd0;
                        data_d  = scan_digit(bcd_next, 4'd0, ovf_q);
                    end
                end
            end
            SCAN: begin
                if (abort) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else if (pos_q == 4'(NDIG - 1)) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    valid_d = 1'b1;
                    pos_d   = pos_q + 4'd1;
                    data_d  = scan_digit(bcd, pos_q + 4'd1, ovf_q);
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= 4'd0;
            pos_q   <= 4'd0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            pos_q   <= pos_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign valid = valid_q;
    assign data  = data_q;
    assign pos   = pos_q;
    assign ovf   = ovf_q;

endmodule

// File: tb/tb_disp_seq_ctrl.sv
// Self-checking bench for disp_seq_ctrl: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a timeline model of the handshake.
module tb_disp_seq_ctrl;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [26:0] value = '0;
    logic        busy, done, valid, ovf;
    logic [3:0]  data, pos;

    int n_checks = 0;
    int n_pass   = 0;

    // Model: t = edges since the accepting edge (-1 when idle), plus captured value/overflow.
    int          t     = -1;
    longint      m_val = 0;
    bit          m_ovf = 1'b0;

    disp_seq_ctrl dut (
        .clock (clock),
        .reset (reset),
        .start (start),
        .abort (abort),
        .value (value),
        .busy  (busy),
        .done  (done),
        .valid (valid),
        .data  (data),
        .pos   (pos),
        .ovf   (ovf)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [3:0] exp_digit(input longint v, input bit o, input int p);
        int     d[8];
        int     msd;
        longint x;
        msd = 0;
        x   = v;
        for (int i = 0; i < 8; i++) begin
            d[i] = int'(x % 10);
            x    = x / 10;
            if (d[i] != 0) msd = i;
        end
        if (o) return 4'hF;
        if (p > 0 && p > msd) return 4'hA;
        return 4'(d[p]);
    endfunction

    always @(posedge clock) begin
        if (!reset) begin
            t     = -1;
            m_ovf = 1'b0;
        end else if (t >= 0) begin
            if (abort || t == 35) t = -1;
            else t = t + 1;
        end else if (start && !abort) begin
            t     = 0;
            m_val = longint'(value);
            m_ovf = value > 27'd99_999_999;
        end
    end

    always @(negedge clock) begin
        logic        e_busy, e_valid, e_done;
        logic [3:0]  e_pos, e_data;
        e_busy  = (t >= 0 && t <= 34);
        e_valid = (t >= 27 && t <= 34);
        e_done  = (t == 35);
        e_pos   = e_valid ? 4'(t - 27) : 4'd0;
        e_data  = e_valid ? exp_digit(m_val, m_ovf, t - 27) : 4'd0;
        check("cycle outputs {busy,done,valid,ovf,pos,data}",
              {20'd0, busy, done, valid, ovf, pos, data},
              {20'd0, e_busy, e_done, e_valid, m_ovf, e_pos, e_data});
    end

    // Runs one start pulse and records the scanned digits packed as nibble[pos] = data.
    task automatic run_txn(input logic [26:0] v, input int restart_a, input int restart_b,
                           input int abort_at, output logic [31:0] rec, output int first_v,
                           output int done_k, output int done_n, output int nvalid,
                           output logic ovf_seen);
        rec = '0; first_v = -1; done_k = -1; done_n = 0; nvalid = 0; ovf_seen = 1'b0;
        @(negedge clock);
        start = 1'b1;
        value = v;
        for (int k = 0; k <= 45; k++) begin
            @(negedge clock);
            if (valid) begin
                if (first_v < 0) first_v = k;
                if (pos != 4'(nvalid)) check("scan pos order", {28'd0, pos}, nvalid);
                if (pos < 4'd8) rec[4*pos +: 4] = data;
                nvalid++;
            end
            if (done) begin
                done_k = k;
                done_n++;
            end
            if (k == 40) ovf_seen = ovf;
            start = (k == restart_a || k == restart_b);
            if (start) value = 27'd5;
            abort = (k == abort_at);
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic directed(input string name, input logic [26:0] v, input logic [31:0] exp_rec,
                            input logic exp_ovf, input int ra, input int rb);
        logic [31:0] rec;
        int          fv, dk, dn, nv;
        logic        o;
        run_txn(v, ra, rb, -1, rec, fv, dk, dn, nv, o);
        check({name, " digits"}, rec, exp_rec);
        check({name, " first valid edge"}, fv, 27);
        check({name, " done edge"}, dk, 35);
        check({name, " done count"}, dn, 1);
        check({name, " valid count"}, nv, 8);
        check({name, " ovf"}, {31'd0, o}, {31'd0, exp_ovf});
    endtask

    initial begin
        logic [31:0] rec;
        int          fv, dk, dn, nv;
        logic        o;

        repeat (2) @(negedge clock);
        check("reset outputs", {20'd0, busy, done, valid, ovf, pos, data}, 32'd0);
        reset = 1'b1;
        @(negedge clock);

        directed("1234", 27'd1234, 32'hAAAA1234, 1'b0, -1, -1);
        directed("zero", 27'd0, 32'hAAAAAAA0, 1'b0, -1, -1);
        directed("max", 27'd99_999_999, 32'h99999999, 1'b0, -1, -1);
        directed("ovf", 27'd100_000_000, 32'hFFFFFFFF, 1'b1, -1, -1);
        directed("restart ignored", 27'd1234, 32'hAAAA1234, 1'b0, 5, 30);

        // Abort raised while the third digit is on the bus.
        run_txn(27'd1234, -1, -1, 29, rec, fv, dk, dn, nv, o);
        check("abort digits", rec, 32'h00000234);
        check("abort valid count", nv, 3);
        check("abort done count", dn, 0);
        check("abort busy", {31'd0, busy}, 32'd0);
        directed("after abort", 27'd7, 32'hAAAAAAA7, 1'b0, -1, -1);

        // Reset in the middle of conversion.
        @(negedge clock);
        start = 1'b1;
        value = 27'd1234;
        @(negedge clock);
        start = 1'b0;
        repeat (8) @(negedge clock);
        #2 reset = 1'b0;
        @(negedge clock);
        check("mid-reset outputs", {20'd0, busy, done, valid, ovf, pos, data}, 32'd0);
        reset = 1'b1;
        directed("after reset", 27'd42, 32'hAAAAAA42, 1'b0, -1, -1);

        // Free-running random traffic; the per-cycle model checks every output.
        for (int c = 0; c < 4000; c++) begin
            @(negedge clock);
            start = ($urandom_range(0, 9) == 0);
            abort = ($urandom_range(0, 59) == 0);
            case ($urandom_range(0, 3))
                0: value = 27'($urandom_range(0, 999));
                1: value = 27'($urandom_range(99_999_990, 100_000_010));
                2: value = 27'($urandom_range(0, 99_999_999));
                default: value = 27'($urandom);
            endcase
        end
        start = 1'b0;
        abort = 1'b0;
        repeat (40) @(negedge clock);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
